// File: rtl/rotate_multi_if.sv
// -----------------------------------------------------------------------------
// rotate_multi_if
//   Bundles the control inputs and display outputs of rotate_multi.
//   The master side drives the controls and observes the display.
//   The slave side is used by the animator itself.
//
//   enable        master->slave  run the step timer and auto-advance
//   clockwise     master->slave  circular direction (1 = increment)
//   mode          master->slave  0 = circular wrap, 1 = bounce between ends
//   step          master->slave  one-cycle manual advance, honoured when !enable
//   sseg_pattern  slave->master  active-low segments of the lit digit
//   an            slave->master  active-low digit enables, one bit low
//   pos           slave->master  current position 0..2*NUM_DIGITS-1
//   adv_tick      slave->master  one-cycle pulse in the cycle pos changes
// -----------------------------------------------------------------------------
interface rotate_multi_if #(
    parameter int NUM_DIGITS = 4
);
    localparam int POS_W = $clog2(2 * NUM_DIGITS);

    logic                  enable;
    logic                  clockwise;
    logic                  mode;
    logic                  step;
    logic [7:0]            sseg_pattern;
    logic [NUM_DIGITS-1:0] an;
    logic [POS_W-1:0]      pos;
    logic                  adv_tick;

    modport master (
        output enable, clockwise, mode, step,
        input  sseg_pattern, an, pos, adv_tick
    );

    modport slave (
        input  enable, clockwise, mode, step,
        output sseg_pattern, an, pos, adv_tick
    );
endinterface

// File: rtl/rotate_multi.sv
// -----------------------------------------------------------------------------
// rotate_multi
//   Animates a square around NUM_DIGITS seven-segment digits. Positions
//   0..N-1 light the lower square moving left->right, positions N..2N-1
//   light the upper square moving right->left. Only one digit is lit at a
//   time, so the outputs drive the SSEG pins directly.
//
//   clk    system clock, rising edge
//   reset  synchronous, active-high
//   bus    rotate_multi_if.slave: enable, clockwise, mode, step in;
//          sseg_pattern, an, pos, adv_tick out
// -----------------------------------------------------------------------------
module rotate_multi #(
    parameter int          NUM_DIGITS   = 4,
    parameter int          DVSR         = 100_000_000,
    parameter logic [7:0]  LOW_PATTERN  = 8'b1010_0001,
    parameter logic [7:0]  HIGH_PATTERN = 8'b1101_1110
) (
    input  logic           clk,
    input  logic           reset,
    rotate_multi_if.slave  bus
);
    localparam int P     = 2 * NUM_DIGITS;
    localparam int POS_W = $clog2(P);
    localparam int TMR_W = $clog2(DVSR);

    localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(DVSR - 1);
    localparam logic [TMR_W-1:0] TMR_ONE = TMR_W'(1);
    localparam logic [POS_W-1:0] POS_MAX = POS_W'(P - 1);
    localparam logic [POS_W-1:0] POS_ONE = POS_W'(1);

    // Bounce direction is a two-state machine.
    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    logic [TMR_W-1:0] timer_q;
    logic [POS_W-1:0] pos_q;
    logic [POS_W-1:0] pos_d;
    dir_e             dir_q;
    dir_e             dir_d;
    logic             tick;
    logic             adv;
    logic             adv_tick_q;
    logic [7:0]       sseg_d;
    logic [NUM_DIGITS-1:0] an_d;

    // Manual step only counts while the timer is stopped.
    assign tick = bus.enable && (timer_q == TMR_MAX);
    assign adv  = tick || (bus.step && !bus.enable);

    // Step timer: holds its count while disabled so a resume continues
    // the interrupted period instead of restarting it.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            timer_q <= '0;
        end else if (bus.enable) begin
            timer_q <= (timer_q == TMR_MAX) ? '0 : timer_q + TMR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pos_q      <= '0;
            dir_q      <= DIR_UP;
            adv_tick_q <= 1'b0;
        end else begin
            pos_q      <= pos_d;
            dir_q      <= dir_d;
            adv_tick_q <= adv;
        end
    end

    // Next position and bounce direction. Wraps and turns are explicit
    // compares because P need not be a power of two.
    // NOTE: every variable gets a default before any branch, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        pos_d = pos_q;
        dir_d = dir_q;

        // In circular mode the bounce direction tracks clockwise, so a later
        // switch to bounce continues in the same direction.
        if (!bus.mode) begin
            dir_d = bus.clockwise ? DIR_UP : DIR_DOWN;
        end

        if (adv) begin
            if (!bus.mode) begin
                if (bus.clockwise) begin
                    pos_d = (pos_q == POS_MAX) ? '0 : pos_q + POS_ONE;
                end else begin
                    pos_d = (pos_q == '0) ? POS_MAX : pos_q - POS_ONE;
                end
            end else if (dir_q == DIR_UP) begin
                // Turn at the end without repeating the end position.
                if (pos_q == POS_MAX) begin
                    pos_d = POS_MAX - POS_ONE;
                    dir_d = DIR_DOWN;
                end else begin
                    pos_d = pos_q + POS_ONE;
                end
            end else begin
                if (pos_q == '0) begin
                    pos_d = POS_ONE;
                    dir_d = DIR_UP;
                end else begin
                    pos_d = pos_q - POS_ONE;
                end
            end
        end
    end

    // Display decode straight from the position register. Upper-square
    // positions walk the digits in reverse.
    always_comb begin
        sseg_d = 8'hFF;
        an_d   = '1;
        if (int'(pos_q) < NUM_DIGITS) begin
            sseg_d = LOW_PATTERN;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (int'(pos_q) == i) an_d[i] = 1'b0;
            end
        end else if (int'(pos_q) < P) begin
            sseg_d = HIGH_PATTERN;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (int'(pos_q) == P - 1 - i) an_d[i] = 1'b0;
            end
        end
    end

    assign bus.sseg_pattern = sseg_d;
    assign bus.an           = an_d;
    assign bus.pos          = pos_q;
    assign bus.adv_tick     = adv_tick_q;

endmodule

// File: tb/tb_rotate_multi.sv
// -----------------------------------------------------------------------------
// tb_rotate_multi
//   Directed bench for rotate_multi: a 4-digit instance and a 3-digit
//   instance, both with DVSR=4. Inputs change and outputs are sampled on
//   the falling clock edge.
// -----------------------------------------------------------------------------
module tb_rotate_multi;
    logic clk    = 1'b0;
    logic reset  = 1'b1;
    logic reset3 = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    rotate_multi_if #(.NUM_DIGITS(4)) bus4 ();
    rotate_multi_if #(.NUM_DIGITS(3)) bus3 ();

    rotate_multi #(.NUM_DIGITS(4), .DVSR(4)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4.slave)
    );

    rotate_multi #(.NUM_DIGITS(3), .DVSR(4)) dut3 (
        .clk   (clk),
        .reset (reset3),
        .bus   (bus3.slave)
    );

    always #5 clk = ~clk;

    // Hand-written decode tables for each position.
    logic [3:0] an4_tbl [8] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111,
                                4'b0111, 4'b1011, 4'b1101, 4'b1110};
    logic [2:0] an3_tbl [6] = '{3'b110, 3'b101, 3'b011,
                                3'b011, 3'b101, 3'b110};
    int bounce_tbl [15] = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1};

    task automatic check(input string tag, input logic [31:0] actual,
                         input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check4(input string tag, input int p, input logic a);
        check({tag, "_pos"},  32'(bus4.pos),          32'(p));
        check({tag, "_an"},   32'(bus4.an),           32'(an4_tbl[p]));
        check({tag, "_sseg"}, 32'(bus4.sseg_pattern), (p < 4) ? 32'hA1 : 32'hDE);
        check({tag, "_adv"},  32'(bus4.adv_tick),     32'(a));
    endtask

    task automatic check3(input string tag, input int p, input logic a);
        check({tag, "_pos"},  32'(bus3.pos),          32'(p));
        check({tag, "_an"},   32'(bus3.an),           32'(an3_tbl[p]));
        check({tag, "_sseg"}, 32'(bus3.sseg_pattern), (p < 3) ? 32'hA1 : 32'hDE);
        check({tag, "_adv"},  32'(bus3.adv_tick),     32'(a));
    endtask

    // One timed step of the 4-digit instance: adv_tick low one cycle after
    // the previous step, then the new position after the full period.
    task automatic step4(input string tag, input int p);
        cycles(1);
        check({tag, "_gap"}, 32'(bus4.adv_tick), 32'd0);
        cycles(3);
        check4(tag, p, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus4.enable = 1'b0; bus4.clockwise = 1'b1; bus4.mode = 1'b0; bus4.step = 1'b0;
        bus3.enable = 1'b0; bus3.clockwise = 1'b1; bus3.mode = 1'b0; bus3.step = 1'b0;

        // Reset values.
        cycles(2);
        check4("rst", 0, 1'b0);

        // Circular clockwise: one step per 4 clocks, full lap back to 0.
        reset = 1'b0;
        bus4.enable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step4($sformatf("cw%0d", i), (i + 1) % 8);
        end

        // Circular counter-clockwise from 0 wraps to 7.
        bus4.clockwise = 1'b0;
        step4("ccw0", 7);
        step4("ccw1", 6);

        // Reset mid-animation, then bounce from 0 through both ends.
        reset = 1'b1;
        cycles(1);
        check4("rst_mid", 0, 1'b0);
        reset = 1'b0;
        bus4.mode = 1'b1;
        bus4.clockwise = 1'b1;
        for (int i = 0; i < 15; i++) begin
            step4($sformatf("bnc%0d", i), bounce_tbl[i]);
        end

        // Manual stepping with the timer frozen at 2.
        bus4.mode = 1'b0;
        cycles(2);
        bus4.enable = 1'b0;
        bus4.step = 1'b1;
        cycles(1);
        check4("man_step", 2, 1'b1);
        bus4.step = 1'b0;
        cycles(50);
        check4("man_hold", 2, 1'b0);
        // Step ignored while enabled; the held count then ticks after 2 clocks.
        bus4.enable = 1'b1;
        bus4.step = 1'b1;
        cycles(1);
        check4("en_step_ign", 2, 1'b0);
        bus4.step = 1'b0;
        cycles(1);
        check4("resume", 3, 1'b1);

        // Bounce starts in the last circular direction (down), ignoring clockwise.
        bus4.enable = 1'b0;
        bus4.clockwise = 1'b0;
        cycles(1);
        bus4.mode = 1'b1;
        bus4.clockwise = 1'b1;
        bus4.step = 1'b1;
        cycles(1);
        check4("bnc_dir", 2, 1'b1);
        bus4.step = 1'b0;

        // Three-digit instance: six positions, wrap 5 -> 0, then one more step.
        check3("d3_rst", 0, 1'b0);
        reset3 = 1'b0;
        bus3.enable = 1'b1;
        for (int i = 0; i < 7; i++) begin
            cycles(4);
            check3($sformatf("d3_cw%0d", i), (i + 1) % 6, 1'b1);
        end
        // Reset with the timer at 2 restarts at position 0 and timer 0.
        cycles(2);
        reset3 = 1'b1;
        cycles(1);
        check3("d3_rst_mid", 0, 1'b0);
        reset3 = 1'b0;
        cycles(3);
        check3("d3_restart", 0, 1'b0);
        cycles(1);
        check3("d3_first", 1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
